// File: rtl/gshare_predictor_if.sv
// Purpose : Bundles the fetch-side prediction port and the execute-side training
//           port of the gshare branch direction predictor.
// Ports   : pred_* (fetch asks, predictor answers combinationally),
//           upd_* (execute reports resolved branches back to the predictor).
// Latency : no flow control; every asserted valid is consumed on the edge it is seen.
interface gshare_predictor_if #(
  parameter int INDEX_BITS = 6,
  parameter int XLEN       = 32
);
  // Fetch side
  logic                  pred_valid;
  logic [XLEN-1:0]       pred_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_ghr;

  // Execute side
  logic                  upd_valid;
  logic [XLEN-1:0]       upd_pc;
  logic [INDEX_BITS-1:0] upd_ghr;
  logic                  upd_taken;
  logic                  upd_mispredict;

  // Pipeline drives requests and resolutions
  modport master (
    output pred_valid, pred_pc,
    output upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    input  pred_taken, pred_ghr
  );

  // Predictor answers predictions and absorbs training
  modport slave (
    input  pred_valid, pred_pc,
    input  upd_valid, upd_pc, upd_ghr, upd_taken, upd_mispredict,
    output pred_taken, pred_ghr
  );
endinterface

// File: rtl/gshare_predictor.sv
// Purpose : Gshare direction predictor: 2-bit saturating counters indexed by
//           pc[INDEX_BITS+1:2] ^ GHR, with a speculative GHR repaired on mispredict.
// Latency : prediction is combinational; training and GHR changes are visible 1 cycle later.
// Backpr. : none; prediction and update are both accepted every cycle.
// Ports   : clock, reset (synchronous, active-high), bp (gshare_predictor_if.slave).
module gshare_predictor #(
  parameter int         INDEX_BITS = 6,
  parameter logic [1:0] CTR_INIT   = 2'b01,
  parameter int         XLEN       = 32
) (
  input  logic               clock,
  input  logic               reset,
  gshare_predictor_if.slave  bp
);

  localparam int DEPTH = 1 << INDEX_BITS;

  // Counter table and global history
  logic [1:0]            r_ctr [DEPTH];
  logic [INDEX_BITS-1:0] r_ghr;

  logic [INDEX_BITS-1:0] w_pred_idx;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic                  w_pred_taken;
  logic [1:0]            w_ctr_cur;
  logic [1:0]            w_ctr_nxt;
  logic                  w_repair;

  // PC bits [1:0] and the bits above the index never participate in hashing
  logic w_unused_pc;
  assign w_unused_pc = ^{bp.pred_pc[XLEN-1:INDEX_BITS+2], bp.pred_pc[1:0],
                         bp.upd_pc[XLEN-1:INDEX_BITS+2],  bp.upd_pc[1:0]};

  assign w_pred_idx = bp.pred_pc[INDEX_BITS+1:2] ^ r_ghr;
  assign w_upd_idx  = bp.upd_pc[INDEX_BITS+1:2]  ^ bp.upd_ghr;

  // Read happens against the registered table, so a same-cycle update to the
  // same entry is only seen by the next prediction (read-before-write).
  assign w_pred_taken  = bp.pred_valid & r_ctr[w_pred_idx][1];
  assign bp.pred_taken = w_pred_taken;
  assign bp.pred_ghr   = r_ghr;

  assign w_ctr_cur = r_ctr[w_upd_idx];
  assign w_repair  = bp.upd_valid & bp.upd_mispredict;

  // Saturating increment / decrement of the trained counter
  always_comb begin
    w_ctr_nxt = w_ctr_cur;
    if (bp.upd_taken) begin
      if (w_ctr_cur != 2'b11) w_ctr_nxt = w_ctr_cur + 2'b01;
    end else begin
      if (w_ctr_cur != 2'b00) w_ctr_nxt = w_ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
      r_ghr <= '0;
    end else begin
      if (bp.upd_valid) r_ctr[w_upd_idx] <= w_ctr_nxt;

      // Repair rebuilds history from the branch's own snapshot plus its real
      // outcome; any younger speculative shift this cycle is on the wrong path.
      if (w_repair)
        r_ghr <= {bp.upd_ghr[INDEX_BITS-2:0], bp.upd_taken};
      else if (bp.pred_valid)
        r_ghr <= {r_ghr[INDEX_BITS-2:0], w_pred_taken};
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Purpose : Directed + randomized check of gshare_predictor against an
//           arithmetic reference model (integer counters, integer history).
// Ports   : none; instantiates gshare_predictor_if and the DUT.
module tb_gshare_predictor;
  localparam int IB   = 6;
  localparam int XLEN = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  gshare_predictor_if #(.INDEX_BITS(IB), .XLEN(XLEN)) bp ();

  gshare_predictor #(.INDEX_BITS(IB), .CTR_INIT(2'b01), .XLEN(XLEN)) dut (
    .clock (clock),
    .reset (reset),
    .bp    (bp)
  );

  // Reference model: counters as small integers 0..3, history as an integer 0..63
  int m_ctr [64];
  int m_ghr;
  int ncmp  = 0;
  int nfail = 0;
  int snaps[$];

  function automatic int m_idx(input int pc, input int h);
    return ((pc >> 2) % 64) ^ (h % 64);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit pv, input int ppc, input bit uv, input int upc,
                       input int ughr, input bit ut, input bit um, input bit rst);
    bp.pred_valid     = pv;
    bp.pred_pc        = ppc;
    bp.upd_valid      = uv;
    bp.upd_pc         = upc;
    bp.upd_ghr        = ughr[IB-1:0];
    bp.upd_taken      = ut;
    bp.upd_mispredict = um;
    reset             = rst;
  endtask

  // Check outputs against the model, then let one edge happen and advance the model.
  task automatic step(input string tag);
    int exp_t;
    int ui;
    @(negedge clock);
    exp_t = bp.pred_valid ? (m_ctr[m_idx(int'(bp.pred_pc), m_ghr)] >= 2) : 0;
    chk({tag, ".taken"}, {31'd0, bp.pred_taken}, exp_t);
    chk({tag, ".ghr"}, {26'd0, bp.pred_ghr}, m_ghr);
    if (reset) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_ghr = 0;
    end else begin
      if (bp.upd_valid) begin
        ui = m_idx(int'(bp.upd_pc), int'(bp.upd_ghr));
        if (bp.upd_taken) m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
        else              m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end
      if (bp.upd_valid && bp.upd_mispredict)
        m_ghr = (int'(bp.upd_ghr) * 2 + int'(bp.upd_taken)) % 64;
      else if (bp.pred_valid)
        m_ghr = (m_ghr * 2 + exp_t) % 64;
    end
    @(posedge clock);
    #1;
  endtask

  // Look at a prediction without letting an edge consume it; exp_t < 0 skips direction.
  task automatic peek(input string tag, input int pc, input int exp_t, input int exp_ghr);
    drive(1'b1, pc, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    if (exp_t >= 0) chk({tag, ".taken"}, {31'd0, bp.pred_taken}, exp_t);
    chk({tag, ".ghr"}, {26'd0, bp.pred_ghr}, exp_ghr);
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int pc, upc, ughr;
    bit pv, uv, ut, um, rst;

    // Bring-up: first edge clears unknown state, model starts from reset values
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #1;
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_ghr = 0;
    step("rst");

    // 1: first prediction after reset is weakly not-taken, history shifts in 0
    drive(1'b1, 'h104, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("p1.taken", {31'd0, bp.pred_taken}, 0);
    step("p1");

    // 2: one taken update flips idx 1 to predict taken
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b0);
    step("p2u");
    drive(1'b1, 'h104, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("p2.taken", {31'd0, bp.pred_taken}, 1);
    step("p2");
    peek("p2g", 'h000, 1, 6'b000001);

    // 3: saturation at idx 1 (GHR is now 1, so pc 0x000 also hits idx 1)
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 0, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b0);
      step("p3t");
    end
    peek("p3sat", 'h000, 1, 1);
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b0, 1'b0, 1'b0);
    step("p3n1");
    peek("p3ctr10", 'h000, 1, 1);
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b0, 1'b0, 1'b0);
    step("p3n2");
    peek("p3ctr01", 'h000, 0, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 0, 1'b1, 'h104, 0, 1'b0, 1'b0, 1'b0);
      step("p3n34");
    end
    peek("p3ctr00", 'h000, 0, 1);
    // From 00 a single taken update must land on 01 (still not-taken)
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b0);
    step("p3floor");
    peek("p3floor", 'h000, 0, 1);

    // 4: repair to 111111, then repair vs. speculative shift in the same cycle
    drive(1'b0, 0, 1'b1, 'h200, 'b011111, 1'b1, 1'b1, 1'b0);
    step("p4a");
    peek("p4ghr", 'h000, -1, 6'b111111);
    drive(1'b1, 'h104, 1'b1, 'h200, 'b000101, 1'b1, 1'b1, 1'b0);
    step("p4b");
    peek("p4repair", 'h000, -1, 6'b001011);
    // Mispredict without valid is ignored: history and table untouched
    drive(1'b0, 0, 1'b0, 'h200, 'b000000, 1'b0, 1'b1, 1'b0);
    step("p4ign");
    peek("p4ign", 'h000, -1, 6'b001011);

    // 5: read-before-write on a same-index collision
    drive(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step("p5rst");
    drive(1'b1, 'h104, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("p5.same", {31'd0, bp.pred_taken}, 0);
    step("p5");
    peek("p5.next", 'h104, 1, 0);

    // 6: train idx 1 to 11, history to 101010, then reset with a live update
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b0);
    step("p6t");
    drive(1'b0, 0, 1'b1, 'h000, 'b010101, 1'b0, 1'b1, 1'b0);
    step("p6g");
    peek("p6trained", 'h0AC, 1, 6'b101010);
    drive(1'b0, 0, 1'b1, 'h104, 0, 1'b1, 1'b0, 1'b1);
    step("p6rst");
    peek("p6after", 'h104, 0, 0);
    peek("p6other", 'h0AC, 0, 0);

    // Randomized traffic with returned snapshots and occasional reset
    for (int n = 0; n < 600; n++) begin
      pv   = ($urandom_range(0, 3) != 0);
      pc   = $urandom_range(0, 511);
      uv   = ($urandom_range(0, 2) != 0);
      upc  = $urandom_range(0, 511);
      if (snaps.size() > 0 && $urandom_range(0, 1) == 1)
        ughr = snaps[$urandom_range(0, snaps.size() - 1)];
      else
        ughr = $urandom_range(0, 63);
      ut   = $urandom_range(0, 1);
      um   = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      drive(pv, pc, uv, upc, ughr, ut, um, rst);
      if (pv) begin
        snaps.push_back(m_ghr);
        if (snaps.size() > 8) void'(snaps.pop_front());
      end
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
